// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants: divider state encodings and default width
package mips_pkg;

  localparam int DIV_WIDTH = 32;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_RUN  = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - operand magnitude conditioning and result sign / divide-by-zero correction
module div_sign_fix
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] op_raw,
  input  logic             op_signed,
  output logic [WIDTH-1:0] op_mag,
  input  logic [WIDTH-1:0] res_mag,
  input  logic             res_neg,
  input  logic             div0,
  input  logic [WIDTH-1:0] div0_val,
  output logic [WIDTH-1:0] res_out
);

  always_comb begin
    op_mag = (op_signed && op_raw[WIDTH-1]) ? (~op_raw + 1'b1) : op_raw;
  end

  // Divide-by-zero results bypass sign correction entirely.
  always_comb begin
    if (div0) begin
      res_out = div0_val;
    end else if (res_neg) begin
      res_out = ~res_mag + 1'b1;
    end else begin
      res_out = res_mag;
    end
  end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider for DIV/DIVU with pipeline stall and flush
module div_iter
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic [WIDTH-1:0] a_mag, b_mag, quot_fix, rmd_fix;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub, rem_next, dvd_next;
  logic             q_bit;

  // The shifted partial remainder is one bit wider than the divisor so the
  // compare is exact; after a successful subtract the result fits WIDTH bits.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign q_bit    = (shifted >= {1'b0, dvs_q});
  assign sub      = shifted[WIDTH-1:0] - dvs_q;
  assign rem_next = q_bit ? sub : shifted[WIDTH-1:0];
  assign dvd_next = {dvd_q[WIDTH-2:0], q_bit};

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .op_raw   (a),
    .op_signed(signed_op),
    .op_mag   (a_mag),
    .res_mag  (dvd_next),
    .res_neg  (q_neg_q),
    .div0     (div0_q),
    .div0_val ({WIDTH{1'b1}}),
    .res_out  (quot_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rmd (
    .op_raw   (b),
    .op_signed(signed_op),
    .op_mag   (b_mag),
    .res_mag  (rem_next),
    .res_neg  (r_neg_q),
    .div0     (div0_q),
    .div0_val (a_raw_q),
    .res_out  (rmd_fix)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    a_raw_d = a_raw_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rmd_d   = rmd_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          a_raw_d = a;
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          q_neg_d = (a[WIDTH-1] ^ b[WIDTH-1]) & signed_op;
          r_neg_d = a[WIDTH-1] & signed_op;
          div0_d  = (b == '0);
          count_d = CW'(WIDTH);
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        rem_d   = rem_next;
        dvd_d   = dvd_next;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = DIV_DONE;
          done_d  = 1'b1;
          quot_d  = quot_fix;
          rmd_d   = rmd_fix;
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // A flush abandons the divide; visible results stay as they were.
    if (cancel) begin
      state_d = DIV_IDLE;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rmd_d   = rmd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_raw_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      a_raw_q <= a_raw_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
    end
  end

  assign stall     = start & (state_q != DIV_DONE) & ~rst & ~cancel;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - randomized self-checking bench for div_iter against an arithmetic reference
module tb_div_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, signed_op, cancel;
  logic [W-1:0] a, b;
  logic         stall, done;
  logic [W-1:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_q, last_r;

  div_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_op(signed_op),
    .cancel   (cancel),
    .a        (a),
    .b        (b),
    .stall    (stall),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MIPS semantics straight from the arithmetic: truncating division, remainder
  // takes the dividend's sign, divide-by-zero gives all ones and the dividend.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                output logic [W-1:0] eq, output logic [W-1:0] er);
    longint sa, sb, q, r;
    if (mb == '0) begin
      eq = '1;
      er = ma;
    end else if (ms) begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      q  = sa / sb;
      r  = sa % sb;
      eq = q[W-1:0];
      er = r[W-1:0];
    end else begin
      eq = ma / mb;
      er = ma % mb;
    end
  endfunction

  task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                         output int cyc, output logic ok);
    a = ta; b = tb; signed_op = ts; start = 1'b1;
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (stall) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic ts, input logic b2b);
    logic [W-1:0] eq, er;
    int cyc;
    logic ok;
    model(ta, tb, ts, eq, er);
    run_div(ta, tb, ts, cyc, ok);
    check({tag, "_done_seen"}, 64'(ok), 64'(1));
    check({tag, "_stall_cycles"}, 64'(cyc), 64'(W + 1));
    check({tag, "_quotient"}, 64'(quotient), 64'(eq));
    check({tag, "_remainder"}, 64'(remainder), 64'(er));
    last_q = eq;
    last_r = er;
    if (b2b) begin
      @(negedge clk);
    end else begin
      start = 1'b0;
      @(negedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           pick;

    rst = 1'b1; start = 1'b1; signed_op = 1'b0; cancel = 1'b0;
    a = 32'd100; b = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_quotient", 64'(quotient), 64'(0));
    check("reset_remainder", 64'(remainder), 64'(0));
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    do_op("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
    do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    do_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0);
    do_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);

    // Flush on the 10th RUN cycle, with start still high into IDLE.
    a = 32'd1000; b = 32'd3; signed_op = 1'b0; start = 1'b1;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel_stall_low", 64'(stall), 64'(0));
    repeat (2) @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) check("cancel_no_done", 64'(done), 64'(0));
      @(negedge clk);
    end
    check("cancel_keep_quotient", 64'(quotient), 64'(last_q));
    check("cancel_keep_remainder", 64'(remainder), 64'(last_r));
    do_op("after_cancel_9_3", 32'd9, 32'd3, 1'b0, 1'b0);

    // Reset in the middle of a divide.
    a = 32'd77; b = 32'd5; signed_op = 1'b0; start = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_quotient", 64'(quotient), 64'(0));
    check("midrst_remainder", 64'(remainder), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_stall", 64'(stall), 64'(0));
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    do_op("b2b_first", 32'd1234567, 32'd89, 1'b0, 1'b1);
    do_op("b2b_second", 32'hFFFF_FC00, 32'd7, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 7);
      if (pick == 0) rb = '0;
      if (pick == 1) rb = '1;
      if (pick == 2) ra = 32'h8000_0000;
      if (pick == 3) rb = 32'($urandom_range(1, 20));
      if (pick == 4) ra = 32'($urandom_range(0, 50));
      do_op($sformatf("rand%0d", n), ra, rb, rs, 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
